if_id_skid_reg: RTL and testbench
=================================

Name: if_id_skid_reg

Overview:
- Parametrised IF/ID pipeline boundary register with valid/ready handshake, optional 2-entry skid buffer, synchronous flush with NOP bubble output, and a saturating flush-discard counter.
- Sits between fetch and decode and replaces the fixed 32-bit stall/NOP register.
- Lets fetch run ahead by one entry while decode back-pressures.
- Flush on branch/jump redirect discards in-flight fetches.

Parameters:
- XLEN, 32, width of pc, pc_nxt and instr fields.
- NOP_INSTR, 32'h00000013, instruction word presented while no valid entry is held (addi x0,x0,0).
- SKID, 1, 1 = two-entry skid buffer (full-throughput, registered in_ready); 0 = single entry (combinational in_ready).
- CNT_W, 8, width of the flush-discard counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous flush; discards all held entries.
- in_valid  input  1  fetch presents an entry.
- in_ready  output  1  block can accept an entry this cycle.
- in_pc  input  XLEN  fetch PC.
- in_pc_nxt  input  XLEN  PC+4 of the fetched instruction.
- in_instr  input  XLEN  fetched instruction word.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode accepts the head entry.
- out_pc  output  XLEN  head PC; 0 when empty.
- out_pc_nxt  output  XLEN  head PC+4; 0 when empty.
- out_instr  output  XLEN  head instruction; NOP_INSTR when empty.
- occupancy  output  2  number of valid entries held (0..2; max 1 when SKID=0).
- flush_cnt  output  CNT_W  count of flushes that discarded at least one valid entry; saturates at all-ones.

Behaviour:
- Reset (rst_n low, async):
  - state EMPTY, out_valid=0, out_pc=0, out_pc_nxt=0, out_instr=NOP_INSTR.
  - occupancy=0, flush_cnt=0.
  - in_ready=1 for SKID=1 (registered); follows the combinational rule for SKID=0.
  - Reset asserted mid-transfer drops all entries; no partial update is visible.
- Handshakes: accept_in = in_valid & in_ready; accept_out = out_valid & out_ready. Both are evaluated on the rising edge.
- Latency: an entry accepted in cycle N appears at the outputs in cycle N+1 (out_valid=1).
- Head registers drive the outputs directly; no combinational path from in_* to out_*.
- SKID=1 states: EMPTY, ONE (main full), TWO (main + skid full).
  - EMPTY: accept_in -> ONE, main<=in.
  - ONE: accept_in & accept_out -> ONE, main<=in. accept_in only -> TWO, skid<=in. accept_out only -> EMPTY.
  - TWO: in_ready=0, so no input is accepted. accept_out -> ONE, main<=skid.
  - in_ready is registered: it is 1 in EMPTY and ONE, and 0 in TWO.
- SKID=0 states: EMPTY, ONE.
  - in_ready = ~out_valid | out_ready (combinational from out_ready).
  - ONE with accept_in & accept_out stays in ONE with main<=in.
- Empty outputs: whenever out_valid=0, out_pc=0, out_pc_nxt=0 and out_instr=NOP_INSTR.
- Flush:
  - Highest priority. On the next edge the state becomes EMPTY and the outputs show the NOP/zero values.
  - An input accepted in the flush cycle is dropped; in_ready is still driven by the normal rule.
  - An output consumed in the flush cycle still counts as delivered to decode.
  - flush_cnt increments by 1 if occupancy>0 at the edge, even if that entry was simultaneously consumed.
  - flush_cnt holds at 2^CNT_W-1 once reached.
- Data ordering is strictly FIFO; the skid entry is never overtaken.
- Outputs are stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset then streaming: release rst_n, hold out_ready=1, feed pc=0x00,0x04,0x08 with instr 0x00500093,0x00100113,0x002081B3 on consecutive cycles. Required: each appears one cycle later in order, in_ready stays 1, occupancy stays 1.
- Back-pressure (SKID=1): hold out_ready=0 and feed two entries (pc 0x10, 0x14). Required: occupancy=2 and in_ready=0; out_pc holds 0x10. Raise out_ready: 0x10 then 0x14 delivered, in_ready returns to 1 one cycle after the first drain.
- Flush with two entries held: assert flush for one cycle. Required next cycle: out_valid=0, out_instr=0x00000013, out_pc=0, occupancy=0, flush_cnt=1. A second flush while empty leaves flush_cnt=1.
- Flush coincident with accept_in of pc=0x20. Required: 0x20 is not delivered, and the next accepted entry, pc=0x24, is delivered.
- SKID=0 build: out_ready=0 with one entry held. Required: in_ready=0 in the same cycle. Raising out_ready gives in_ready=1 combinationally, with simultaneous replace and occupancy staying 1.
- Async reset mid-stream with occupancy=2: pull rst_n low between clock edges. Required: outputs immediately show out_valid=0, out_instr=0x00000013, flush_cnt=0. With CNT_W=2, 5 discarding flushes saturate flush_cnt at 3.

Source files
------------

// File: rtl/if_id_skid_reg.sv
// IF/ID boundary register: valid/ready handshake, optional second (skid) entry,
// synchronous flush that bubbles a NOP, and a saturating count of discarding flushes.
module if_id_skid_reg #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013),
  parameter int              SKID      = 1,
  parameter int              CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_pc_nxt,
  input  logic [XLEN-1:0]  in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_pc_nxt,
  output logic [XLEN-1:0]  out_instr,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] instr;
  } entry_t;

  // The head register is reloaded with this bubble whenever the block empties,
  // so the outputs are driven straight from flops with no output mux.
  localparam entry_t EMPTY_ENTRY = '{pc: '0, pc_nxt: '0, instr: NOP_INSTR};

  state_t     state_reg, state_next;
  entry_t     main_reg, main_next;
  entry_t     skid_reg, skid_next;
  logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;
  entry_t     in_entry;
  logic       accept_in;
  logic       accept_out;

  assign in_entry   = '{pc: in_pc, pc_nxt: in_pc_nxt, instr: in_instr};
  assign accept_in  = in_valid & in_ready;
  assign accept_out = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_EMPTY;
      main_reg      <= EMPTY_ENTRY;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      main_reg      <= main_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  // The skid entry is only observable after being moved into main, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_reg <= skid_next;
  end

  // Next-state logic
  always_comb begin
    state_next     = state_reg;
    main_next      = main_reg;
    skid_next      = skid_reg;
    flush_cnt_next = flush_cnt_reg;

    if (flush) begin
      state_next = ST_EMPTY;
      main_next  = EMPTY_ENTRY;
      if ((state_reg != ST_EMPTY) && !(&flush_cnt_reg)) begin
        flush_cnt_next = flush_cnt_reg + CNT_W'(1);
      end
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept_in) begin
            state_next = ST_ONE;
            main_next  = in_entry;
          end
        end
        ST_ONE: begin
          if (accept_in && accept_out) begin
            main_next = in_entry;
          end else if (accept_in && (SKID != 0)) begin
            state_next = ST_TWO;
            skid_next  = in_entry;
          end else if (accept_out) begin
            state_next = ST_EMPTY;
            main_next  = EMPTY_ENTRY;
          end
        end
        ST_TWO: begin
          if (accept_out) begin
            state_next = ST_ONE;
            main_next  = skid_reg;
          end
        end
        default: begin
          state_next = ST_EMPTY;
          main_next  = EMPTY_ENTRY;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (state_reg)
      ST_ONE: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      ST_TWO: begin
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: begin
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
    endcase
  end

  assign out_pc     = main_reg.pc;
  assign out_pc_nxt = main_reg.pc_nxt;
  assign out_instr  = main_reg.instr;
  assign flush_cnt  = flush_cnt_reg;

  generate
    if (SKID != 0) begin : g_skid
      // Registered ready: low exactly while both entries are occupied.
      logic in_ready_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          in_ready_reg <= 1'b1;
        end else begin
          in_ready_reg <= (state_next != ST_TWO);
        end
      end
      assign in_ready = in_ready_reg;
    end else begin : g_single
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: a two-entry build with a 2-bit counter and a single-entry
// build share stimulus; each is checked against a FIFO-queue model of its own.
module tb_if_id_skid_reg;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_pc_nxt = '0;
  logic [31:0] in_instr = '0;

  logic        v1, r1, v0, r0;
  logic [31:0] pc1, pn1, ins1, pc0, pn0, ins0;
  logic [1:0]  occ1, occ0, cnt1;
  logic [7:0]  cnt0;

  if_id_skid_reg #(.XLEN(32), .NOP_INSTR(NOP), .SKID(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r1),
    .in_pc(in_pc), .in_pc_nxt(in_pc_nxt), .in_instr(in_instr),
    .out_valid(v1), .out_ready(out_ready),
    .out_pc(pc1), .out_pc_nxt(pn1), .out_instr(ins1),
    .occupancy(occ1), .flush_cnt(cnt1)
  );

  if_id_skid_reg #(.XLEN(32), .NOP_INSTR(NOP), .SKID(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r0),
    .in_pc(in_pc), .in_pc_nxt(in_pc_nxt), .in_instr(in_instr),
    .out_valid(v0), .out_ready(out_ready),
    .out_pc(pc0), .out_pc_nxt(pn0), .out_instr(ins0),
    .occupancy(occ0), .flush_cnt(cnt0)
  );

  always #5 clk = ~clk;

  logic [100:0] act1;
  logic [106:0] act0;
  assign act1 = {v1, pc1, pn1, ins1, occ1, cnt1};
  assign act0 = {v0, pc0, pn0, ins0, occ0, cnt0};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pn;
    logic [31:0] ins;
  } ent_t;

  ent_t        q1[$];
  ent_t        q0[$];
  int unsigned m_cnt1 = 0;
  int unsigned m_cnt0 = 0;
  logic [31:0] del1[$];
  int          checks = 0;
  int          failures = 0;

  // Model: a queue of capacity 2 (two-entry build) or 1 (single-entry build).
  function automatic logic rdy1();
    return q1.size() < 2;
  endfunction

  function automatic logic rdy0();
    return (q0.size() == 0) || out_ready;
  endfunction

  function automatic logic [100:0] exp1();
    if (q1.size() > 0) return {1'b1, q1[0].pc, q1[0].pn, q1[0].ins, 2'(q1.size()), 2'(m_cnt1)};
    return {1'b0, 32'h0, 32'h0, NOP, 2'd0, 2'(m_cnt1)};
  endfunction

  function automatic logic [106:0] exp0();
    if (q0.size() > 0) return {1'b1, q0[0].pc, q0[0].pn, q0[0].ins, 2'(q0.size()), 8'(m_cnt0)};
    return {1'b0, 32'h0, 32'h0, NOP, 2'd0, 8'(m_cnt0)};
  endfunction

  task automatic drive(input bit f, input bit iv, input bit ord,
                       input logic [31:0] pc, input logic [31:0] ins);
    flush     = f;
    in_valid  = iv;
    out_ready = ord;
    in_pc     = pc;
    in_pc_nxt = pc + 32'd4;
    in_instr  = ins;
    #1;
  endtask

  // Advance one clock and apply the same edge to both models.
  task automatic tick();
    bit   a1, a0, o1, o0;
    int   n1, n0;
    ent_t e;
    e  = '{in_pc, in_pc_nxt, in_instr};
    a1 = in_valid && rdy1();
    a0 = in_valid && rdy0();
    o1 = (q1.size() > 0) && out_ready;
    o0 = (q0.size() > 0) && out_ready;
    n1 = q1.size();
    n0 = q0.size();
    if (v1 && out_ready) del1.push_back(pc1);
    @(posedge clk);
    if (o1) begin
      $display("xfer skid1 pc=%h instr=%h", q1[0].pc, q1[0].ins);
      void'(q1.pop_front());
    end
    if (o0) void'(q0.pop_front());
    if (flush) begin
      if (n1 > 0 && m_cnt1 < 3) m_cnt1++;
      if (n0 > 0 && m_cnt0 < 255) m_cnt0++;
      q1.delete();
      q0.delete();
    end else begin
      if (a1) q1.push_back(e);
      if (a0) q0.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (act1 !== exp1()) begin failures++; $display("FAIL reset_skid1 got=%h exp=%h", act1, exp1()); end
    checks++;
    if (act0 !== exp0()) begin failures++; $display("FAIL reset_single got=%h exp=%h", act0, exp0()); end
    checks++;
    if (r1 !== 1'b1 || r0 !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b%b exp=11", r1, r0); end
    rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    logic [31:0] pcs[3];
    logic [31:0] ins[3];
    pcs = '{32'h00, 32'h04, 32'h08};
    ins = '{32'h00500093, 32'h00100113, 32'h002081B3};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, pcs[i], ins[i]);
      checks++;
      if (r1 !== 1'b1) begin failures++; $display("FAIL stream_ready got=%b exp=1", r1); end
      tick();
      checks++;
      if (act1 !== exp1() || pc1 !== pcs[i] || ins1 !== ins[i] || occ1 !== 2'd1) begin
        failures++; $display("FAIL stream_out got=%h exp=%h", act1, exp1());
      end
      checks++;
      if (act0 !== exp0()) begin failures++; $display("FAIL stream_single got=%h exp=%h", act0, exp0()); end
    end
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    tick();
  endtask

  task automatic test_backpressure();
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h11111111);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h14, 32'h22222222);
    tick();
    checks++;
    if (occ1 !== 2'd2 || r1 !== 1'b0 || pc1 !== 32'h10) begin
      failures++; $display("FAIL bp_full got occ=%0d rdy=%b pc=%h exp occ=2 rdy=0 pc=10", occ1, r1, pc1);
    end
    checks++;
    if (act0 !== exp0() || r0 !== 1'b0) begin failures++; $display("FAIL bp_single got=%h exp=%h", act0, exp0()); end
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    tick();
    checks++;
    if (act1 !== exp1() || pc1 !== 32'h14 || r1 !== 1'b1) begin
      failures++; $display("FAIL bp_drain1 got pc=%h rdy=%b exp pc=14 rdy=1", pc1, r1);
    end
    tick();
    checks++;
    if (act1 !== exp1() || v1 !== 1'b0) begin failures++; $display("FAIL bp_drain2 got=%h exp=%h", act1, exp1()); end
  endtask

  task automatic test_flush();
    drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h33333333);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h44, 32'h44444444);
    tick();
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    tick();
    checks++;
    if (v1 !== 1'b0 || ins1 !== NOP || pc1 !== 32'h0 || occ1 !== 2'd0 || cnt1 !== 2'd1) begin
      failures++; $display("FAIL flush_full got v=%b ins=%h pc=%h occ=%0d cnt=%0d exp 0/00000013/0/0/1",
                           v1, ins1, pc1, occ1, cnt1);
    end
    checks++;
    if (act0 !== exp0()) begin failures++; $display("FAIL flush_single got=%h exp=%h", act0, exp0()); end
    tick();
    checks++;
    if (cnt1 !== 2'd1 || act1 !== exp1()) begin failures++; $display("FAIL flush_empty got cnt=%0d exp=1", cnt1); end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_flush_accept();
    int n20, n24;
    del1.delete();
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h55555555);
    tick();
    checks++;
    if (act1 !== exp1() || v1 !== 1'b0) begin failures++; $display("FAIL flush_acc_drop got=%h exp=%h", act1, exp1()); end
    drive(1'b0, 1'b1, 1'b1, 32'h24, 32'h66666666);
    tick();
    checks++;
    if (pc1 !== 32'h24 || act1 !== exp1()) begin failures++; $display("FAIL flush_acc_next got pc=%h exp=24", pc1); end
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    tick();
    n20 = 0;
    n24 = 0;
    foreach (del1[i]) begin
      if (del1[i] == 32'h20) n20++;
      if (del1[i] == 32'h24) n24++;
    end
    checks++;
    if (n20 != 0 || n24 != 1) begin failures++; $display("FAIL flush_acc_deliver got n20=%0d n24=%0d exp 0 1", n20, n24); end
  endtask

  task automatic test_skid0();
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h30, 32'h77777777);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h34, 32'h88888888);
    checks++;
    if (r0 !== 1'b0 || r0 !== rdy0()) begin failures++; $display("FAIL single_stall got rdy=%b exp=0", r0); end
    out_ready = 1'b1;
    #1;
    checks++;
    if (r0 !== 1'b1) begin failures++; $display("FAIL single_comb_ready got rdy=%b exp=1", r0); end
    tick();
    checks++;
    if (pc0 !== 32'h34 || occ0 !== 2'd1 || act0 !== exp0()) begin
      failures++; $display("FAIL single_replace got pc=%h occ=%0d exp pc=34 occ=1", pc0, occ0);
    end
    checks++;
    if (act1 !== exp1()) begin failures++; $display("FAIL single_skid1 got=%h exp=%h", act1, exp1()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 19) == 0), $urandom_range(0, 1), ($urandom_range(0, 2) != 0),
            {$urandom_range(0, 32'h3FFF), 2'b00}, $urandom);
      checks++;
      if (r1 !== rdy1() || r0 !== rdy0()) begin
        failures++; $display("FAIL rand_ready cyc=%0d got=%b%b exp=%b%b", i, r1, r0, rdy1(), rdy0());
      end
      tick();
      checks++;
      if (act1 !== exp1()) begin failures++; $display("FAIL rand_skid1 cyc=%0d got=%h exp=%h", i, act1, exp1()); end
      checks++;
      if (act0 !== exp0()) begin failures++; $display("FAIL rand_single cyc=%0d got=%h exp=%h", i, act0, exp0()); end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h50, 32'h99999999);
    tick();
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h60, 32'hAAAAAAAA);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h64, 32'hBBBBBBBB);
    tick();
    checks++;
    if (occ1 !== 2'd2 || cnt1 === 2'd0) begin failures++; $display("FAIL arst_setup got occ=%0d cnt=%0d exp occ=2 cnt>0", occ1, cnt1); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (v1 !== 1'b0 || ins1 !== NOP || cnt1 !== 2'd0 || occ1 !== 2'd0 || pc1 !== 32'h0) begin
      failures++; $display("FAIL arst_skid1 got v=%b ins=%h cnt=%0d occ=%0d exp 0/00000013/0/0", v1, ins1, cnt1, occ1);
    end
    checks++;
    if (v0 !== 1'b0 || ins0 !== NOP || cnt0 !== 8'd0) begin failures++; $display("FAIL arst_single got v=%b ins=%h cnt=%0d", v0, ins0, cnt0); end
    q1.delete();
    q0.delete();
    m_cnt1 = 0;
    m_cnt0 = 0;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h100 + 32'(i * 4), $urandom);
      tick();
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      tick();
    end
    checks++;
    if (cnt1 !== 2'd3 || act1 !== exp1()) begin failures++; $display("FAIL sat_skid1 got cnt=%0d exp=3", cnt1); end
    checks++;
    if (cnt0 !== 8'd5 || act0 !== exp0()) begin failures++; $display("FAIL sat_single got cnt=%0d exp=5", cnt0); end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_flush_accept();
    test_skid0();
    test_random();
    test_async_reset();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
